// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic library: divider state encoding,
// divide-by-zero quotient constant and sizing helpers.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [255:0] DIV_ZERO_Q = '1;

  function automatic int ctr_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Number of 4-bit lookahead groups needed to cover an n-bit operand.
  function automatic int cla_groups(input int n);
    return (n + 3) / 4;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake bundle between a requester and the sequential divider.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/cla_subtractor.sv
// Combinational a - b as a + ~b + 1 using 4-bit carry-lookahead groups;
// carry_out high means the subtraction did not borrow.
module cla_subtractor
  import arith_pkg::*;
#(
  parameter int N = 9
) (
  input  logic [N-1:0]             a,
  input  logic [N-1:0]             b,
  output logic [N-1:0]             diff,
  output logic                     carry_out,
  output logic [cla_groups(N)-1:0] gg,
  output logic [cla_groups(N)-1:0] pp
);

  localparam int NG = cla_groups(N);
  localparam int NP = NG * 4;

  logic [N-1:0]  bNot;
  logic [NP-1:0] aExt;
  logic [NP-1:0] bInv;
  logic [NP-1:0] g;
  logic [NP-1:0] p;
  logic [NP:0]   c;
  logic          unusedCarries;

  // Padding bits have g = p = 0 so they neither generate nor pass a carry.
  assign bNot = ~b;
  assign aExt = NP'(a);
  assign bInv = NP'(bNot);
  assign g    = aExt & bInv;
  assign p    = aExt ^ bInv;
  assign c[0] = 1'b1;

  for (genvar j = 0; j < NG; j++) begin : gGroup
    localparam int B = 4 * j;

    assign gg[j] = g[B+3]
                 | (p[B+3] & g[B+2])
                 | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign pp[j] = &p[B+3:B];

    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign c[B+4] = gg[j] | (pp[j] & c[B]);
  end

  assign diff          = p[N-1:0] ^ c[N-1:0];
  assign carry_out     = c[N];
  assign unusedCarries = ^{c, p};

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock through
// a CLA subtractor, with a start/done handshake and divide-by-zero flag.
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_restoring_divider_if.slave bus
);

  localparam int CTR_W = ctr_width(WIDTH);
  localparam int NG    = cla_groups(WIDTH + 1);

  div_state_e       state_q;
  logic [WIDTH:0]   remPart_q;
  logic [WIDTH:0]   remPart_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quoShift_q;
  logic [WIDTH-1:0] quoShift_d;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic [CTR_W-1:0] ctr_q;
  logic             busy_q;
  logic             done_q;
  logic             divByZero_q;
  logic             noBorrow;
  logic [NG-1:0]    grpGen;
  logic [NG-1:0]    grpProp;
  logic             unusedBits;

  assign shifted = {remPart_q[WIDTH-1:0], quoShift_q[WIDTH-1]};

  cla_subtractor #(
    .N(WIDTH + 1)
  ) uSub (
    .a        (shifted),
    .b        ({1'b0, divisor_q}),
    .diff     (trial),
    .carry_out(noBorrow),
    .gg       (grpGen),
    .pp       (grpProp)
  );

  assign remPart_d  = noBorrow ? trial : shifted;
  assign quoShift_d = {quoShift_q[WIDTH-2:0], noBorrow};
  assign unusedBits = ^{grpGen, grpProp, remPart_q[WIDTH]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remPart_q   <= '0;
      quoShift_q  <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ctr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      divByZero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            divisor_q  <= bus.divisor;
            remPart_q  <= '0;
            quoShift_q <= bus.dividend;
            ctr_q      <= CTR_W'(WIDTH);
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          // A zero divisor spends one RUN edge; the untouched shift register
          // still holds the dividend, which becomes the reported remainder.
          if (divisor_q == '0) begin
            quotient_q  <= DIV_ZERO_Q[WIDTH-1:0];
            remainder_q <= quoShift_q;
            divByZero_q <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            remPart_q  <= remPart_d;
            quoShift_q <= quoShift_d;
            ctr_q      <= ctr_q - CTR_W'(1);
            if (ctr_q == CTR_W'(1)) begin
              quotient_q  <= quoShift_d;
              remainder_q <= remPart_d[WIDTH-1:0];
              divByZero_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = divByZero_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider at WIDTH=8 and WIDTH=16,
// compared against plain integer division.
module tb_seq_restoring_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH(8))  bus8 ();
  seq_restoring_divider_if #(.WIDTH(16)) bus16 ();

  seq_restoring_divider #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8.slave)
  );

  seq_restoring_divider #(.WIDTH(16)) dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus16.slave)
  );

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic driveOp(input bit wide, input logic [15:0] a, input logic [15:0] b,
                         input logic st);
    if (wide) begin
      bus16.dividend = a;
      bus16.divisor  = b;
      bus16.start    = st;
    end else begin
      bus8.dividend = a[7:0];
      bus8.divisor  = b[7:0];
      bus8.start    = st;
    end
  endtask

  function automatic logic getDone(input bit wide);
    return wide ? bus16.done : bus8.done;
  endfunction

  function automatic logic getBusy(input bit wide);
    return wide ? bus16.busy : bus8.busy;
  endfunction

  function automatic logic [15:0] getQ(input bit wide);
    return wide ? bus16.quotient : {8'h00, bus8.quotient};
  endfunction

  function automatic logic [15:0] getR(input bit wide);
    return wide ? bus16.remainder : {8'h00, bus8.remainder};
  endfunction

  function automatic logic getDz(input bit wide);
    return wide ? bus16.div_by_zero : bus8.div_by_zero;
  endfunction

  // Reference: ordinary integer division, with the all-ones/dividend rule for b == 0.
  task automatic refModel(input bit wide, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic [15:0] r, output logic dz,
                          output int lat);
    if (b == 16'd0) begin
      q   = wide ? 16'hFFFF : 16'h00FF;
      r   = a;
      dz  = 1'b1;
      lat = 1;
    end else begin
      q   = a / b;
      r   = a % b;
      dz  = 1'b0;
      lat = wide ? 16 : 8;
    end
  endtask

  // Presents one request for a single edge, then counts edges until done (bounded).
  task automatic runOp(input bit wide, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output logic dz,
                       output int lat);
    driveOp(wide, a, b, 1'b1);
    stepEdge();
    driveOp(wide, a, b, 1'b0);
    lat = 0;
    while (getDone(wide) !== 1'b1 && lat < 100) begin
      stepEdge();
      lat++;
    end
    q  = getQ(wide);
    r  = getR(wide);
    dz = getDz(wide);
  endtask

  task automatic test_reset();
    driveOp(1'b0, 16'd0, 16'd0, 1'b0);
    driveOp(1'b1, 16'd0, 16'd0, 1'b0);
    rst_n = 1'b0;
    stepEdge();
    stepEdge();
    rst_n = 1'b1;
    stepEdge();
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (getBusy(w[0]) !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_busy w%0d: got %b want 0", w, getBusy(w[0]));
      end
      checks++;
      if (getDone(w[0]) !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_done w%0d: got %b want 0", w, getDone(w[0]));
      end
      checks++;
      if (getQ(w[0]) !== 16'd0) begin
        errors++;
        $display("[TB] FAIL reset_quotient w%0d: got %h want 0", w, getQ(w[0]));
      end
      checks++;
      if (getR(w[0]) !== 16'd0) begin
        errors++;
        $display("[TB] FAIL reset_remainder w%0d: got %h want 0", w, getR(w[0]));
      end
      checks++;
      if (getDz(w[0]) !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_dbz w%0d: got %b want 0", w, getDz(w[0]));
      end
    end
  endtask

  task automatic test_directed();
    logic [15:0] as [5] = '{16'd100, 16'd5, 16'd255, 16'd255, 16'd77};
    logic [15:0] bs [5] = '{16'd7, 16'd9, 16'd1, 16'd255, 16'd0};
    logic [15:0] q, r, eq, er;
    logic        dz, edz;
    int          lat, elat;
    for (int i = 0; i < 5; i++) begin
      refModel(1'b0, as[i], bs[i], eq, er, edz, elat);
      runOp(1'b0, as[i], bs[i], q, r, dz, lat);
      checks++;
      if (lat !== elat) begin
        errors++;
        $display("[TB] FAIL dir_latency %0d/%0d: got %0d want %0d", as[i], bs[i], lat, elat);
      end
      checks++;
      if (q !== eq) begin
        errors++;
        $display("[TB] FAIL dir_quotient %0d/%0d: got %0d want %0d", as[i], bs[i], q, eq);
      end
      checks++;
      if (r !== er) begin
        errors++;
        $display("[TB] FAIL dir_remainder %0d/%0d: got %0d want %0d", as[i], bs[i], r, er);
      end
      checks++;
      if (dz !== edz) begin
        errors++;
        $display("[TB] FAIL dir_dbz %0d/%0d: got %b want %b", as[i], bs[i], dz, edz);
      end
      stepEdge();
      checks++;
      if (getBusy(1'b0) !== 1'b0 || getDone(1'b0) !== 1'b0) begin
        errors++;
        $display("[TB] FAIL dir_after_done %0d/%0d: busy %b done %b want 0 0",
                 as[i], bs[i], getBusy(1'b0), getDone(1'b0));
      end
    end
  endtask

  task automatic test_start_held();
    int lat;
    driveOp(1'b0, 16'd100, 16'd7, 1'b1);
    stepEdge();
    driveOp(1'b0, 16'd9, 16'd3, 1'b1);
    lat = 0;
    while (bus8.done !== 1'b1 && lat < 100) begin
      stepEdge();
      lat++;
    end
    checks++;
    if (lat !== 8 || bus8.quotient !== 8'd14 || bus8.remainder !== 8'd2) begin
      errors++;
      $display("[TB] FAIL held_first: lat %0d q %0d r %0d want 8 14 2",
               lat, bus8.quotient, bus8.remainder);
    end
    stepEdge();
    checks++;
    if (bus8.busy !== 1'b0 || bus8.quotient !== 8'd14) begin
      errors++;
      $display("[TB] FAIL held_idle_gap: busy %b q %0d want 0 14", bus8.busy, bus8.quotient);
    end
    stepEdge();
    checks++;
    if (bus8.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL held_second_accept: busy %b want 1", bus8.busy);
    end
    bus8.start = 1'b0;
    lat = 0;
    while (bus8.done !== 1'b1 && lat < 100) begin
      stepEdge();
      lat++;
    end
    checks++;
    if (lat !== 8 || bus8.quotient !== 8'd3 || bus8.remainder !== 8'd0) begin
      errors++;
      $display("[TB] FAIL held_second: lat %0d q %0d r %0d want 8 3 0",
               lat, bus8.quotient, bus8.remainder);
    end
    stepEdge();
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] q, r;
    logic        dz;
    int          lat;
    int          donePulses;
    driveOp(1'b0, 16'd200, 16'd3, 1'b1);
    stepEdge();
    driveOp(1'b0, 16'd200, 16'd3, 1'b0);
    stepEdge();
    stepEdge();
    stepEdge();
    rst_n = 1'b0;
    stepEdge();
    rst_n = 1'b1;
    checks++;
    if (bus8.busy !== 1'b0 || bus8.quotient !== 8'd0 || bus8.remainder !== 8'd0
        || bus8.div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: busy %b q %0d r %0d dbz %b want all 0",
               bus8.busy, bus8.quotient, bus8.remainder, bus8.div_by_zero);
    end
    donePulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done === 1'b1) donePulses++;
      stepEdge();
    end
    checks++;
    if (donePulses !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_no_done: got %0d pulses want 0", donePulses);
    end
    runOp(1'b0, 16'd200, 16'd3, q, r, dz, lat);
    checks++;
    if (lat !== 8 || q !== 16'd66 || r !== 16'd2 || dz !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_rerun: lat %0d q %0d r %0d dbz %b want 8 66 2 0",
               lat, q, r, dz);
    end
    stepEdge();
  endtask

  task automatic test_random();
    logic [15:0] a, b, q, r, eq, er, mask;
    logic        dz, edz;
    logic [31:0] recon;
    int          lat, elat;
    for (int w = 0; w < 2; w++) begin
      mask = w[0] ? 16'hFFFF : 16'h00FF;
      for (int i = 0; i < 1000; i++) begin
        a = 16'($urandom) & mask;
        if ($urandom_range(0, 15) == 0) b = 16'd0;
        else if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 4));
        else b = 16'($urandom) & mask;
        refModel(w[0], a, b, eq, er, edz, elat);
        runOp(w[0], a, b, q, r, dz, lat);
        checks++;
        if (lat !== elat) begin
          errors++;
          $display("[TB] FAIL rnd_latency w%0d %0d/%0d: got %0d want %0d", w, a, b, lat, elat);
        end
        checks++;
        if (q !== eq || r !== er || dz !== edz) begin
          errors++;
          $display("[TB] FAIL rnd_result w%0d %0d/%0d: got q%0d r%0d z%b want q%0d r%0d z%b",
                   w, a, b, q, r, dz, eq, er, edz);
        end
        if (b != 16'd0) begin
          recon = 32'(q) * 32'(b) + 32'(r);
          checks++;
          if (recon !== 32'(a) || !(r < b)) begin
            errors++;
            $display("[TB] FAIL rnd_invariant w%0d %0d/%0d: q*b+r %0d r %0d want %0d r<b",
                     w, a, b, recon, r, a);
          end
        end
        stepEdge();
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_held();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
